// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor:
// counter encodings and default table geometry.
package branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_SNT   = 2'b00;
  localparam bp_ctr_t BP_CTR_WNT   = 2'b01;
  localparam bp_ctr_t BP_CTR_WT    = 2'b10;
  localparam bp_ctr_t BP_CTR_ST    = 2'b11;
  localparam bp_ctr_t BP_CTR_RESET = BP_CTR_WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = BP_CTR_WT;

  localparam int BP_ENTRIES = 16;
  localparam int BP_XLEN    = 32;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state.
// Ports: ctr_in (current), taken (outcome), ctr_out (next).
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    unique case (1'b1)
      (taken && ctr_in != BP_CTR_ST):
        ctr_out = ctr_in + 2'd1;
      (!taken && ctr_in != BP_CTR_SNT):
        ctr_out = ctr_in - 2'd1;
      default: ctr_out = ctr_in;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit predictor + BTB with
// EX-side mispredict detection, training and perf counters.
// Ports: clock/reset, IF lookup (if_pc -> if_pred_*),
// EX resolve (ex_* -> ex_mispredict/ex_redirect_pc),
// branch_count / mispredict_count.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES    = BP_ENTRIES,
  parameter int INDEX_BITS = $clog2(ENTRIES),
  parameter int XLEN       = BP_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int TAG_BITS = XLEN - 2 - INDEX_BITS;

  logic                valid_q [ENTRIES];
  bp_ctr_t             ctr_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Lookup
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign if_pred_taken  = if_hit && ctr_q[if_idx][1];
  assign if_pred_target = if_pred_taken ? tgt_q[if_idx]
                                        : if_pc + XLEN'(4);

  // Resolve
  logic ex_dir_wrong;
  logic ex_tgt_wrong;

  assign ex_dir_wrong  = ex_taken != ex_pred_taken;
  assign ex_tgt_wrong  = ex_taken && (ex_pred_target != ex_target);
  assign ex_mispredict = ex_valid && !reset &&
                         (ex_dir_wrong || ex_tgt_wrong);
  assign ex_redirect_pc = ex_taken ? ex_target
                                   : ex_pc + XLEN'(4);

  // Update
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  logic                  upd;
  logic                  alloc;
  logic [1:0]            ctr_nxt;

  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd    = ex_valid && !reset;
  assign alloc  = upd && !ex_hit && ex_taken;

  bp_sat_counter u_ctr (
    .ctr_in  (ctr_q[ex_idx]),
    .taken   (ex_taken),
    .ctr_out (ctr_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= BP_CTR_RESET;
      end
    end else if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_nxt;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= BP_CTR_ALLOC;
      end
    end
  end

  // Tags/targets carry no reset; valid gates their use.
  always_ff @(posedge clock) begin
    if (alloc) begin
      tag_q[ex_idx] <= ex_tag;
    end
    if (upd && ex_taken) begin
      tgt_q[ex_idx] <= ex_target;
    end
  end

  // Perf counters
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd) begin
      branch_count_d = branch_count_q + 32'd1;
      if (ex_mispredict) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor
// against a behavioural table model.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            ex_mispredict;
  logic [XLEN-1:0] ex_redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  branch_predictor #(
    .ENTRIES    (ENTRIES),
    .INDEX_BITS (4),
    .XLEN       (XLEN)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_mispredict    (ex_mispredict),
    .ex_redirect_pc   (ex_redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string t,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", t, obs, exp);
    end
  endtask

  // Model: entry fields as plain ints, counter 0..3
  bit              m_v   [ENTRIES];
  int unsigned     m_tag [ENTRIES];
  int              m_ctr [ENTRIES];
  logic [XLEN-1:0] m_tgt [ENTRIES];
  int unsigned     m_bc;
  int unsigned     m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_v[i] && (m_tag[i] == tag_of(pc));
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i]   = 0;
      m_ctr[i] = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // One cycle: drive, check combinational and
  // registered outputs, clock, advance the model.
  task automatic cyc(input bit r, input logic [31:0] ipc,
                     input bit v, input logic [31:0] pc,
                     input bit tk, input logic [31:0] tg,
                     input bit ptk, input logic [31:0] ptg);
    bit mp;
    int i;
    reset = r; if_pc = ipc; ex_valid = v; ex_pc = pc;
    ex_taken = tk; ex_target = tg;
    ex_pred_taken = ptk; ex_pred_target = ptg;
    #1;
    mp = v && !r && ((tk != ptk) || (tk && ptg != tg));
    chk("if_pred_taken", 32'(if_pred_taken), 32'(m_pt(ipc)));
    chk("if_pred_target", if_pred_target, m_ptg(ipc));
    chk("ex_mispredict", 32'(ex_mispredict), 32'(mp));
    if (mp)
      chk("ex_redirect_pc", ex_redirect_pc,
          tk ? tg : pc + 32'd4);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    @(posedge clock);
    if (r) begin
      m_reset();
    end else if (v) begin
      i = idx_of(pc);
      if (m_hit(pc)) begin
        m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (tk) m_tgt[i] = tg;
      end else if (tk) begin
        m_v[i] = 1; m_tag[i] = tag_of(pc);
        m_tgt[i] = tg; m_ctr[i] = 2;
      end
      m_bc++;
      if (mp) m_mc++;
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'h1000 + 4 * ($urandom_range(0, 2) * ENTRIES
                           + $urandom_range(0, ENTRIES - 1));
  endfunction

  initial begin
    logic [31:0] tgts [4];
    logic [31:0] pc, ipc, tg, ptg;
    bit ptk, tk, v, r;
    tgts[0] = 32'h80; tgts[1] = 32'h90;
    tgts[2] = 32'h200; tgts[3] = 32'h3000;

    reset = 1; if_pc = 0; ex_valid = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("rst_pt", 32'(if_pred_taken), 32'd0);
    chk("rst_tgt", if_pred_target, 32'h104);
    chk("rst_bc", branch_count, 32'd0);

    // Allocate; same-cycle lookup sees old state
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0);
    chk("alloc_pt", 32'(if_pred_taken), 32'd1);
    chk("alloc_tgt", if_pred_target, 32'h80);
    chk("alloc_bc", branch_count, 32'd1);
    chk("alloc_mc", mispredict_count, 32'd1);

    // Train down: 10 -> 01 -> 00
    cyc(0, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80);
    chk("wnt_pt", 32'(if_pred_taken), 32'd0);
    cyc(0, 32'h100, 1, 32'h100, 0, 0, 0, 0);
    chk("snt_mc", mispredict_count, 32'd2);

    // Alias replacement
    cyc(0, 32'h140, 1, 32'h140, 1, 32'h200, 0, 0);
    chk("alias_pt", 32'(if_pred_taken), 32'd1);
    chk("alias_tgt", if_pred_target, 32'h200);
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("alias_old", 32'(if_pred_taken), 32'd0);

    // Target mismatch, then train same entry
    cyc(0, 32'h140, 1, 32'h140, 1, 32'h90, 1, 32'h200);
    chk("tgt_upd", if_pred_target, 32'h90);

    // Reset together with ex_valid
    cyc(1, 32'h140, 1, 32'h140, 1, 32'h90, 0, 0);
    chk("rst_mid_pt", 32'(if_pred_taken), 32'd0);
    chk("rst_mid_bc", branch_count, 32'd0);
    chk("rst_mid_mc", mispredict_count, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      pc  = rnd_pc();
      ipc = ($urandom_range(0, 1) != 0) ? pc : rnd_pc();
      v   = $urandom_range(0, 9) < 7;
      tk  = $urandom_range(0, 1);
      tg  = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) != 0) begin
        ptk = m_pt(pc);
        ptg = m_ptg(pc);
      end else begin
        ptk = $urandom_range(0, 1);
        ptg = tgts[$urandom_range(0, 3)];
      end
      r = $urandom_range(0, 63) == 0;
      cyc(r, ipc, v, pc, tk, tg, ptk, ptg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the EX-stage branch resolution logic.
- In IF, it predicts direction and target for the current PC. It uses a direct-mapped table of 2-bit saturating counters plus a BTB.
- In EX, it takes the resolved outcome (branch_taken, target, carried prediction). It flags mispredictions, supplies the redirect PC, and trains the table.
- It also keeps branch and mispredict performance counters.

Parameters:
ENTRIES, 16, table entries; power of two, at least 2
INDEX_BITS, 4, log2(ENTRIES)
XLEN, 32, PC/target width
TAG_BITS, XLEN-2-INDEX_BITS, tag width (derived; do not override)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_pc  in  XLEN  fetch PC (word aligned)
if_pred_taken  out  1  predicted taken for if_pc
if_pred_target  out  XLEN  predicted next PC
ex_valid  in  1  conditional branch resolving in EX this cycle (Branch, already qualified by stall/flush)
ex_pc  in  XLEN  PC of the resolving branch
ex_taken  in  1  resolved direction (branch_taken)
ex_target  in  XLEN  resolved taken target
ex_pred_taken  in  1  prediction carried from IF with this branch
ex_pred_target  in  XLEN  predicted target carried from IF
ex_mispredict  out  1  flush/redirect request
ex_redirect_pc  out  XLEN  correct next PC
branch_count  out  32  resolved branches since reset
mispredict_count  out  32  mispredicts since reset

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Address fields: index = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2].
- Entry contents: valid (flop per entry), tag, 2-bit counter, target.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.

Lookup (combinational, 0-cycle latency):
- hit = valid[idx] && tag match.
- if_pred_taken = hit && ctr[1].
- if_pred_target = if_pred_taken ? btb_target : if_pc+4 (mod 2^XLEN).

Resolve (combinational):
- ex_mispredict = ex_valid && !reset && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)).
- ex_redirect_pc = ex_taken ? ex_target : ex_pc+4. Meaningful only when ex_mispredict=1.

Update (rising edge, when ex_valid && !reset):
- Hit: counter saturates toward the outcome (11 stays 11 on taken; 00 stays 00 on not-taken). If taken, the target is rewritten with ex_target.
- Miss and taken: allocate (overwrites any alias). Set valid=1, tag, target=ex_target, ctr=10.
- Miss and not-taken: no change.
- branch_count += 1. mispredict_count += ex_mispredict. Both wrap at 2^32.

Same-cycle lookup and update on the same index:
- Lookup returns the pre-update state; there is no bypass.
- The new state is visible from the next cycle.

Reset:
- All valid bits = 0, all counters = 01, targets/tags don't-care, both perf counters = 0.
- if_pred_taken = 0 (no valid entries), so if_pred_target = if_pc+4. ex_mispredict = 0.
- Reset asserted together with ex_valid: the update is discarded and reset wins.
- Reset mid-stream: state returns to the reset values in exactly one cycle.

Flush:
- The pipeline deasserts ex_valid for squashed branches. Squashed instructions never train the table.

Decomposition:
- constants.vh: BP_CTR_SNT/WNT/WT/ST encodings, BP_CTR_RESET (01), BP_CTR_ALLOC (10).
- config.vh: BP_ENTRIES default.
- Sub-module bp_sat_counter: combinational 2-bit next-state (ctr_in, taken -> ctr_out), instantiated once in the update path.
- Table arrays and perf counters stay in branch_predictor.

Test Plan:
1. Reset, then if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104; branch_count=0, mispredict_count=0.
2. ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> ex_mispredict=1, ex_redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, target=0x80; counts 1/1.
3. From state 2 (ctr=10), resolve 0x100 not-taken with pred_taken=1 -> mispredict=1, redirect=0x104; ctr=01, and the next lookup predicts not-taken. A second not-taken gives ctr=00 and mispredict=0.
4. Alias (ENTRIES=16): 0x100 allocated, lookup 0x140 -> not taken. Resolve 0x140 taken to 0x200 -> entry replaced, 0x140 predicts 0x200, 0x100 now misses.
5. Same index: lookup 0x100 in the cycle its first allocating update happens -> pred_taken=0 that cycle, 1 the next.
6. Target mismatch: pred_taken=1, pred_target=0x80, ex_taken=1, ex_target=0x90 -> mispredict=1, redirect=0x90, BTB updated. Reset with ex_valid=1 -> no update, mispredict=0, counts=0.
